// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter and single-cycle access sequencer for the byte-lane data RAM.
// Port 0 is the CPU load/store unit, port 1 the loader/debug master; bad accesses return err and never write.
module data_mem_arbiter #(
  parameter logic [31:0] MEM_BASE = 32'h0000_0000,
  parameter logic [31:0] MEM_SIZE = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [2:0]  m0_func3,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [2:0]  m1_func3,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        ram_we,
  output logic [2:0]  ram_func3,
  output logic [31:0] ram_address,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state, state_next;
  logic        last_gnt;
  logic        grant;
  logic        sel_port;
  logic        req_we;
  logic [2:0]  req_func3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_err;
  logic        lat_we;
  logic        lat_port;
  logic        lat_err;
  logic [2:0]  lat_func3;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [32:0] addr_ext;
  logic [32:0] win_lo;
  logic [32:0] win_hi;
  logic [31:0] rsp_data;

  // NOTE: every output of a combinational block gets a default first, otherwise an untaken branch infers a latch.
  always_comb begin
    state_next = state;
    grant      = 1'b0;
    sel_port   = 1'b0;
    m0_gnt     = 1'b0;
    m1_gnt     = 1'b0;
    if (state == IDLE) begin
      if (m0_req && m1_req) begin
        grant    = 1'b1;
        sel_port = ~last_gnt;  // the port that did not win last time
      end else if (m0_req) begin
        grant    = 1'b1;
        sel_port = 1'b0;
      end else if (m1_req) begin
        grant    = 1'b1;
        sel_port = 1'b1;
      end
      if (grant) begin
        state_next = ACCESS;
        m0_gnt     = ~sel_port;
        m1_gnt     = sel_port;
      end
    end else begin
      state_next = IDLE;
    end
  end

  assign req_we    = sel_port ? m1_we    : m0_we;
  assign req_func3 = sel_port ? m1_func3 : m0_func3;
  assign req_addr  = sel_port ? m1_addr  : m0_addr;
  assign req_wdata = sel_port ? m1_wdata : m0_wdata;

  // Window check is done at 33 bits so MEM_BASE+MEM_SIZE cannot wrap.
  assign addr_ext = {1'b0, req_addr};
  assign win_lo   = {1'b0, MEM_BASE};
  assign win_hi   = {1'b0, MEM_BASE} + {1'b0, MEM_SIZE};

  assign req_err = (req_func3[1:0] == 2'b11)
                 | ((req_func3[1:0] == 2'b01) & req_addr[0])
                 | ((req_func3[1:0] == 2'b10) & (req_addr[1:0] != 2'b00))
                 | (addr_ext < win_lo) | (addr_ext >= win_hi);

  // NOTE: sequential state is always assigned with non-blocking <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_gnt  <= 1'b1;
      lat_we    <= 1'b0;
      lat_port  <= 1'b0;
      lat_err   <= 1'b0;
      lat_func3 <= 3'b000;
      lat_addr  <= 32'h0;
      lat_wdata <= 32'h0;
      ram_we    <= 1'b0;
    end else begin
      state  <= state_next;
      ram_we <= grant & req_we & ~req_err;
      if (grant) begin
        last_gnt  <= sel_port;
        lat_we    <= req_we;
        lat_port  <= sel_port;
        lat_err   <= req_err;
        lat_func3 <= req_func3;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
      end
    end
  end

  assign ram_func3   = lat_func3;
  assign ram_address = lat_addr;
  assign ram_wdata   = lat_wdata;
  assign rsp_data    = (~lat_we & ~lat_err) ? ram_rdata : 32'h0;

  // Response is captured at the end of ACCESS; rdata/err hold between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_rvalid <= 1'b0;
      m0_rdata  <= 32'h0;
      m0_err    <= 1'b0;
      m1_rvalid <= 1'b0;
      m1_rdata  <= 32'h0;
      m1_err    <= 1'b0;
    end else begin
      m0_rvalid <= (state == ACCESS) & ~lat_port;
      m1_rvalid <= (state == ACCESS) & lat_port;
      if ((state == ACCESS) && !lat_port) begin
        m0_rdata <= rsp_data;
        m0_err   <= lat_err;
      end
      if ((state == ACCESS) && lat_port) begin
        m1_rdata <= rsp_data;
        m1_err   <= lat_err;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a byte-lane RAM model hanging off the ram_* port.
// Inputs change on the falling edge; outputs are sampled 1 time unit after it.
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [2:0]  m0_func3, m1_func3;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ram_we;
  logic [2:0]  ram_func3;
  logic [31:0] ram_address, ram_wdata, ram_rdata;

  int checks = 0;
  int errors = 0;

  data_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_func3(m0_func3), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_func3(m1_func3), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .ram_we(ram_we), .ram_func3(ram_func3), .ram_address(ram_address),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM model: 64 KiB, cleared on the first clock edge, async lane-selected read.
  logic [7:0]  mem [0:65535];
  logic        mem_cleared = 1'b0;
  logic [15:0] ra0, ra1, ra2, ra3;

  always @(posedge clk) begin
    if (!mem_cleared) begin
      for (int i = 0; i < 65536; i++) mem[i] <= 8'h00;
      mem_cleared <= 1'b1;
    end else if (ram_we) begin
      mem[ram_address[15:0]] <= ram_wdata[7:0];
      if (ram_func3[1:0] != 2'b00) mem[ram_address[15:0] + 16'd1] <= ram_wdata[15:8];
      if (ram_func3[1:0] == 2'b10) begin
        mem[ram_address[15:0] + 16'd2] <= ram_wdata[23:16];
        mem[ram_address[15:0] + 16'd3] <= ram_wdata[31:24];
      end
    end
  end

  always_comb begin
    ra0 = ram_address[15:0];
    ra1 = ra0 + 16'd1;
    ra2 = ra0 + 16'd2;
    ra3 = ra0 + 16'd3;
    ram_rdata = 32'h0;
    case (ram_func3[1:0])
      2'b00: ram_rdata = ram_func3[2] ? {24'h0, mem[ra0]} : {{24{mem[ra0][7]}}, mem[ra0]};
      2'b01: ram_rdata = ram_func3[2] ? {16'h0, mem[ra1], mem[ra0]}
                                      : {{16{mem[ra1][7]}}, mem[ra1], mem[ra0]};
      2'b10: ram_rdata = {mem[ra3], mem[ra2], mem[ra1], mem[ra0]};
      default: ram_rdata = 32'h0;
    endcase
  end

  task automatic set_req(input logic port, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata);
    if (port) begin
      m1_req = 1'b1; m1_we = we; m1_func3 = f3; m1_addr = addr; m1_wdata = wdata;
    end else begin
      m0_req = 1'b1; m0_we = we; m0_func3 = f3; m0_addr = addr; m0_wdata = wdata;
    end
  endtask

  task automatic clr_reqs();
    m0_req = 1'b0;
    m1_req = 1'b0;
  endtask

  task automatic apply_reset();
    clr_reqs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, ram_we} !== 7'b0) begin
      errors++;
      $display("FAIL %s ctrl: got gnt=%b%b rvalid=%b%b err=%b%b ram_we=%b, want all 0",
               name, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, ram_we);
    end
    checks++;
    if ({m0_rdata, m1_rdata, ram_address, ram_wdata, ram_func3} !== 131'b0) begin
      errors++;
      $display("FAIL %s data: got rdata=%h/%h addr=%h wdata=%h func3=%b, want all 0",
               name, m0_rdata, m1_rdata, ram_address, ram_wdata, ram_func3);
    end
  endtask

  // One complete transaction on an otherwise idle bus: grant in T, RAM cycle in T+1, response in T+2.
  task automatic do_access(input string name, input logic port, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic exp_err, input logic [31:0] exp_rdata);
    int   waited;
    logic g, rv, er;
    logic [31:0] rd;
    @(negedge clk);
    set_req(port, we, f3, addr, wdata);
    #1;
    waited = 0;
    g = port ? m1_gnt : m0_gnt;
    while (!g && waited < 8) begin
      @(negedge clk); #1;
      waited++;
      g = port ? m1_gnt : m0_gnt;
    end
    checks++;
    if (g !== 1'b1) begin
      errors++;
      $display("FAIL %s gnt: got %b after %0d cycles, want 1", name, g, waited);
      clr_reqs();
      return;
    end
    checks++;
    if ((port ? m0_gnt : m1_gnt) !== 1'b0) begin
      errors++;
      $display("FAIL %s other_gnt: got 1, want 0", name);
    end
    @(negedge clk);
    clr_reqs();
    #1;
    checks++;
    if (ram_we !== (we & ~exp_err)) begin
      errors++;
      $display("FAIL %s ram_we: got %b, want %b", name, ram_we, we & ~exp_err);
    end
    checks++;
    if (ram_address !== addr || ram_func3 !== f3) begin
      errors++;
      $display("FAIL %s ram_addr: got %h/%b, want %h/%b", name, ram_address, ram_func3, addr, f3);
    end
    checks++;
    if ((m0_rvalid | m1_rvalid | m0_gnt | m1_gnt) !== 1'b0) begin
      errors++;
      $display("FAIL %s early_rvalid: got rvalid=%b%b gnt=%b%b, want 0", name, m0_rvalid, m1_rvalid, m0_gnt, m1_gnt);
    end
    @(negedge clk); #1;
    rv = port ? m1_rvalid : m0_rvalid;
    er = port ? m1_err    : m0_err;
    rd = port ? m1_rdata  : m0_rdata;
    checks++;
    if (rv !== 1'b1 || (port ? m0_rvalid : m1_rvalid) !== 1'b0) begin
      errors++;
      $display("FAIL %s rvalid: got m0=%b m1=%b, want only port %0d", name, m0_rvalid, m1_rvalid, port);
    end
    checks++;
    if (er !== exp_err) begin
      errors++;
      $display("FAIL %s err: got %b, want %b", name, er, exp_err);
    end
    checks++;
    if (rd !== exp_rdata) begin
      errors++;
      $display("FAIL %s rdata: got %h, want %h", name, rd, exp_rdata);
    end
    checks++;
    if (ram_we !== 1'b0) begin
      errors++;
      $display("FAIL %s ram_we_after: got %b, want 0", name, ram_we);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    check_all_zero("reset");
  endtask

  task automatic test_store_load();
    do_access("sw_100", 1'b0, 1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 1'b0, 32'h0);
    do_access("lw_100", 1'b0, 1'b0, 3'b010, 32'h100, 32'h0, 1'b0, 32'hDEAD_BEEF);
  endtask

  task automatic test_contention();
    logic e_g0, e_g1, e_r0, e_r1;
    apply_reset();
    set_req(1'b0, 1'b0, 3'b010, 32'h100, 32'h0);
    set_req(1'b1, 1'b0, 3'b010, 32'h104, 32'h0);
    for (int c = 0; c < 9; c++) begin
      #1;
      e_g0 = (c % 4 == 0);
      e_g1 = (c % 4 == 2);
      e_r0 = (c >= 2) && (c % 4 == 2);
      e_r1 = (c >= 4) && (c % 4 == 0);
      checks++;
      if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid} !== {e_g0, e_g1, e_r0, e_r1}) begin
        errors++;
        $display("FAIL contention_c%0d: got gnt=%b%b rvalid=%b%b, want gnt=%b%b rvalid=%b%b",
                 c, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, e_g0, e_g1, e_r0, e_r1);
      end
      if (e_r0) begin
        checks++;
        if (m0_rdata !== 32'hDEAD_BEEF || m0_err !== 1'b0) begin
          errors++;
          $display("FAIL contention_m0_data c%0d: got %h err=%b, want deadbeef err=0", c, m0_rdata, m0_err);
        end
      end
      if (e_r1) begin
        checks++;
        if (m1_rdata !== 32'h0 || m1_err !== 1'b0) begin
          errors++;
          $display("FAIL contention_m1_data c%0d: got %h err=%b, want 0 err=0", c, m1_rdata, m1_err);
        end
      end
      @(negedge clk);
    end
    clr_reqs();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_illegal();
    do_access("sh_101",  1'b1, 1'b1, 3'b001, 32'h101, 32'h0000_1234, 1'b1, 32'h0);
    do_access("sw_102",  1'b1, 1'b1, 3'b010, 32'h102, 32'h5555_AAAA, 1'b1, 32'h0);
    do_access("f3_011",  1'b1, 1'b1, 3'b011, 32'h100, 32'h1111_2222, 1'b1, 32'h0);
    do_access("lw_back", 1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 1'b0, 32'hDEAD_BEEF);
  endtask

  task automatic test_range();
    do_access("sb_top",  1'b0, 1'b1, 3'b000, 32'h0001_0000, 32'h0000_00AB, 1'b1, 32'h0);
    do_access("sb_last", 1'b0, 1'b1, 3'b000, 32'h0000_FFFF, 32'h0000_00AB, 1'b0, 32'h0);
    do_access("lbu_last", 1'b1, 1'b0, 3'b100, 32'h0000_FFFF, 32'h0, 1'b0, 32'h0000_00AB);
  endtask

  task automatic test_sign();
    do_access("sw_200",  1'b0, 1'b1, 3'b010, 32'h200, 32'h0000_80F0, 1'b0, 32'h0);
    do_access("lb_200",  1'b0, 1'b0, 3'b000, 32'h200, 32'h0, 1'b0, 32'hFFFF_FFF0);
    do_access("lbu_200", 1'b1, 1'b0, 3'b100, 32'h200, 32'h0, 1'b0, 32'h0000_00F0);
    do_access("lh_200",  1'b0, 1'b0, 3'b001, 32'h200, 32'h0, 1'b0, 32'hFFFF_80F0);
    do_access("lhu_200", 1'b1, 1'b0, 3'b101, 32'h200, 32'h0, 1'b0, 32'h0000_80F0);
  endtask

  task automatic test_reset_mid_access();
    @(negedge clk);
    set_req(1'b0, 1'b1, 3'b010, 32'h300, 32'h1122_3344);
    #1;
    checks++;
    if (m0_gnt !== 1'b1) begin
      errors++;
      $display("FAIL midrst_gnt: got %b, want 1", m0_gnt);
    end
    @(negedge clk);
    clr_reqs();
    #1;
    checks++;
    if (ram_we !== 1'b1) begin
      errors++;
      $display("FAIL midrst_access: got ram_we=%b, want 1", ram_we);
    end
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst_async");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all_zero("midrst_held");
    @(negedge clk); #1;
    checks++;
    if ({m0_rvalid, m1_rvalid, ram_we} !== 3'b000) begin
      errors++;
      $display("FAIL midrst_no_rsp: got rvalid=%b%b ram_we=%b, want 0", m0_rvalid, m1_rvalid, ram_we);
    end
    @(negedge clk);
    set_req(1'b0, 1'b0, 3'b010, 32'h300, 32'h0);
    set_req(1'b1, 1'b0, 3'b010, 32'h304, 32'h0);
    #1;
    checks++;
    if ({m0_gnt, m1_gnt} !== 2'b10) begin
      errors++;
      $display("FAIL midrst_first_conflict: got gnt=%b%b, want 10", m0_gnt, m1_gnt);
    end
    @(negedge clk);
    clr_reqs();
    @(negedge clk); #1;
    checks++;
    if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h0) begin
      errors++;
      $display("FAIL midrst_dropped_store: got rvalid=%b rdata=%h, want 1/00000000", m0_rvalid, m0_rdata);
    end
    @(negedge clk); #1;
    checks++;
    if ({m0_rvalid, m1_rvalid} !== 2'b00) begin
      errors++;
      $display("FAIL midrst_unserved_m1: got rvalid=%b%b, want 00", m0_rvalid, m1_rvalid);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    m0_req = 1'b0; m0_we = 1'b0; m0_func3 = 3'b000; m0_addr = 32'h0; m0_wdata = 32'h0;
    m1_req = 1'b0; m1_we = 1'b0; m1_func3 = 3'b000; m1_addr = 32'h0; m1_wdata = 32'h0;
    test_reset();
    test_store_load();
    test_contention();
    test_illegal();
    test_range();
    test_sign();
    test_reset_mid_access();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
